mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 131 +++++++++++++
 tb/tb_mem_arb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: arbitrates a fetch port and a data port onto one memory port, one
// transaction outstanding at a time, with a sticky watchdog on long transactions.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests. Without it, data always wins over fetch.
module mem_arb #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ack,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic [31:0] i_d_addr,
  input  logic        i_d_wen,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_mask,
  output logic        o_d_ack,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;    // 1: data owns the transaction, 0: fetch
  logic            last_q, last_d;      // requester granted at the last acceptance
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  logic sel_data;
  logic any_req;
  logic mem_req;
  logic accept;

  // Grant selection: locked to the latched owner while stalled in ISSUE.
  always_comb begin
    any_req = i_if_req | i_d_req;
    if (state_q == StIssue) begin
      sel_data = owner_q;
    end else begin
`ifdef MEM_ARB_RR_EN
      sel_data = (i_if_req & i_d_req) ? ~last_q : i_d_req;
`else
      sel_data = i_d_req;
`endif
    end
    mem_req = ~i_rst & (((state_q == StIdle) & any_req) | (state_q == StIssue));
    accept  = mem_req & i_mem_ready;
  end

  // State register and watchdog.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = sel_data;
          state_d = accept ? StWait : StIssue;
        end
      end
      StIssue: begin
        if (accept) state_d = StWait;
      end
      StWait: begin
        if (i_mem_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (accept) last_d = sel_data;

    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (cnt_q == TimeoutCnt) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    timeout_d = timeout_q | (cnt_d == TimeoutCnt);
  end

  // Output logic; strobes are gated low during reset.
  always_comb begin
    o_mem_req   = mem_req;
    o_mem_addr  = sel_data ? i_d_addr : i_if_addr;
    o_mem_wen   = sel_data & i_d_wen;
    o_mem_wdata = i_d_wdata;
    o_mem_mask  = sel_data ? i_d_mask : 4'b1111;
    o_if_ack    = accept & ~sel_data;
    o_d_ack     = accept & sel_data;
    o_if_rvalid = ~i_rst & (state_q == StWait) & i_mem_rvalid & ~owner_q;
    o_d_rvalid  = ~i_rst & (state_q == StWait) & i_mem_rvalid & owner_q;
    o_if_rdata  = i_mem_rdata;
    o_d_rdata   = i_mem_rdata;
    o_timeout   = timeout_q;
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed, table-driven bench for mem_arb (TIMEOUT=4), plus a
// hand-written watchdog sequence.
module tb_mem_arb;

  localparam logic [31:0] IfAddr = 32'h0000_0100;
  localparam logic [31:0] DAddr  = 32'h0000_2000;
  localparam logic [31:0] DWdata = 32'hBEEF_0000;
  localparam logic [3:0]  DMask  = 4'b1100;

  logic        clk;
  logic        rst;
  logic        if_req, d_req, mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        if_ack, if_rvalid, d_ack, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_req, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  mem_arb #(.TIMEOUT(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_if_req     (if_req),
    .i_if_addr    (IfAddr),
    .o_if_ack     (if_ack),
    .o_if_rvalid  (if_rvalid),
    .o_if_rdata   (if_rdata),
    .i_d_req      (d_req),
    .i_d_addr     (DAddr),
    .i_d_wen      (1'b1),
    .i_d_wdata    (DWdata),
    .i_d_mask     (DMask),
    .o_d_ack      (d_ack),
    .o_d_rvalid   (d_rvalid),
    .o_d_rdata    (d_rdata),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .o_mem_wen    (mem_wen),
    .o_mem_wdata  (mem_wdata),
    .o_mem_mask   (mem_mask),
    .i_mem_ready  (mem_ready),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata),
    .o_timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ifr, dr, rdy, rv;
    logic [31:0] rdata;
    logic        e_req, e_gd, e_ifack, e_dack, e_ifrv, e_drv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic i, logic d, logic rd, logic rv, logic [31:0] rdat,
                              logic eq, logic egd, logic eia, logic eda, logic eir,
                              logic edr);
    vec_t v;
    v.rst = r; v.ifr = i; v.dr = d; v.rdy = rd; v.rv = rv; v.rdata = rdat;
    v.e_req = eq; v.e_gd = egd; v.e_ifack = eia; v.e_dack = eda; v.e_ifrv = eir;
    v.e_drv = edr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Flags a requester dropping its request while its grant is stalled.
  bit stalled = 1'b0;
  always @(posedge clk) begin
    if (stalled && !if_req && !d_req && !rst)
      $display("protocol violation: request dropped while stalled at %0t", $time);
    stalled = mem_req & ~mem_ready & ~rst;
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0;

    //                 rst i  d  rdy rv rdata         req gd ia da ir dr
    // Reset gating and idle.
    vecs.push_back(mk(1, 1, 1, 1, 1, 32'h1,         0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    // Single fetch, then stray rvalid in IDLE.
    vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h00A00093,  0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'hDEAD,      0, 0, 0, 0, 0, 0));
    // Collision: data first, fetch waits for data response.
    vecs.push_back(mk(0, 1, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h11,        0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h22,        0, 0, 0, 0, 1, 0));
    // Stall lock: fetch stalled 3 cycles, data arrives meanwhile.
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 32'h33,        0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h44,        0, 0, 0, 0, 0, 1));
    // Back-to-back collisions from reset (last-grant flag = fetch).
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 32'h55,        0, 0, 0, 0, 0, 1));
`ifdef MEM_ARB_RR_EN
    vecs.push_back(mk(0, 1, 1, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 32'h66,        0, 0, 0, 0, 1, 0));
`else
    vecs.push_back(mk(0, 1, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 32'h66,        0, 0, 0, 0, 0, 1));
`endif
    vecs.push_back(mk(0, 1, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h77,        0, 0, 0, 0, 0, 1));
    // Reset in WAIT, late rvalid ignored, then a normal transaction.
    vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h88,        0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h99,        0, 0, 0, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; if_req = vecs[i].ifr; d_req = vecs[i].dr;
      mem_ready = vecs[i].rdy; mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rdata;
      #2;
      chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d if_ack", i), 32'(if_ack), 32'(vecs[i].e_ifack));
      chk($sformatf("v%0d d_ack", i), 32'(d_ack), 32'(vecs[i].e_dack));
      chk($sformatf("v%0d if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].e_ifrv));
      chk($sformatf("v%0d d_rvalid", i), 32'(d_rvalid), 32'(vecs[i].e_drv));
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_gd ? DAddr : IfAddr);
        chk($sformatf("v%0d mem_wen", i), 32'(mem_wen), 32'(vecs[i].e_gd));
        chk($sformatf("v%0d mem_mask", i), 32'(mem_mask),
            vecs[i].e_gd ? 32'(DMask) : 32'hF);
        if (vecs[i].e_gd) chk($sformatf("v%0d mem_wdata", i), mem_wdata, DWdata);
      end
      if (vecs[i].e_ifrv) chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].rdata);
      if (vecs[i].e_drv) chk($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].rdata);
    end

    // Watchdog: accept, then withhold the response.
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #2 chk("wd after reset", 32'(timeout), 32'h0);
    @(negedge clk);
    if_req = 1'b1; mem_ready = 1'b1;
    #2 chk("wd accept ack", 32'(if_ack), 32'h1);
    @(negedge clk);
    if_req = 1'b0; mem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("wd after wait cycle %0d", k), 32'(timeout), (k == 4) ? 32'h1 : 32'h0);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
    #2 chk("wd late if_rvalid", 32'(if_rvalid), 32'h1);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #2 chk("wd sticky in idle", 32'(timeout), 32'h1);
    chk("wd idle no mem_req", 32'(mem_req), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("wd still sticky", 32'(timeout), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2 chk("wd cleared by reset", 32'(timeout), 32'h0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
